// File: rtl/med_window_gen.sv
// 3x3 neighbourhood generator: buffers two raster lines and serialises each
// interior window as a 9-sample burst (DO/DSO/SOW) for a sequential median filter.
module med_window_gen #(
  parameter int width    = 8,
  parameter int line_len = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] PI,
  input  logic             PVAL,
  input  logic             SOF,
  output logic             PRDY,
  input  logic             WRDY,
  output logic [width-1:0] DO,
  output logic             DSO,
  output logic             SOW,
  output logic [1:0]       fsm_state
);

  localparam int CW = (line_len > 1) ? $clog2(line_len) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(line_len - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    col;
  logic [1:0]       row;
  logic [3:0]       k;
  logic [3:0]       k_inc;
  logic [width-1:0] lb1 [line_len];
  logic [width-1:0] lb2 [line_len];
  logic [width-1:0] win [9];
  logic [width-1:0] win_nxt [9];
  logic             accept;
  logic             win_valid;
  logic [CW-1:0]    cur_col;
  logic [1:0]       cur_row;

  // Pixel handshake: a pixel transfers on a rising edge where PVAL and PRDY are
  // both high; PRDY depends only on state, never on PVAL. WRDY is only sampled
  // when a window is waiting to start, never mid-burst.
  assign PRDY      = (state == S_IDLE);
  assign accept    = PVAL & PRDY;
  assign cur_col   = SOF ? '0 : col;
  assign cur_row   = SOF ? 2'd0 : row;
  assign win_valid = (cur_row == 2'd2) && (cur_col >= CW'(2));
  assign k_inc     = k + 4'd1;
  assign fsm_state = state;

  always_comb begin
    win_nxt = win;
    if (accept) begin
      win_nxt[0] = win[1];
      win_nxt[1] = win[2];
      win_nxt[2] = lb2[cur_col];
      win_nxt[3] = win[4];
      win_nxt[4] = win[5];
      win_nxt[5] = lb1[cur_col];
      win_nxt[6] = win[7];
      win_nxt[7] = win[8];
      win_nxt[8] = PI;
    end
  end

  // Line buffers and window carry no reset: rows below 2 never emit.
  always_ff @(posedge CLK) begin
    if (accept) begin
      lb2[cur_col] <= lb1[cur_col];
      lb1[cur_col] <= PI;
    end
    win <= win_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= 2'd0;
      k     <= 4'd0;
      DO    <= '0;
      DSO   <= 1'b0;
      SOW   <= 1'b0;
    end else begin
      if (accept) begin
        if (cur_col == LAST_COL) begin
          col <= '0;
          row <= (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end
      case (state)
        S_IDLE: begin
          if (accept && win_valid) begin
            if (WRDY) begin
              // Window updates on this same edge, so present the post-shift sample.
              state <= S_EMIT;
              k     <= 4'd0;
              DO    <= win_nxt[0];
              DSO   <= 1'b1;
              SOW   <= 1'b1;
            end else begin
              state <= S_PEND;
            end
          end
        end
        S_PEND: begin
          if (WRDY) begin
            state <= S_EMIT;
            k     <= 4'd0;
            DO    <= win[0];
            DSO   <= 1'b1;
            SOW   <= 1'b1;
          end
        end
        S_EMIT: begin
          SOW <= 1'b0;
          if (k == 4'd8) begin
            state <= S_IDLE;
            k     <= 4'd0;
            DO    <= '0;
            DSO   <= 1'b0;
          end else begin
            k  <= k_inc;
            DO <= win[k_inc];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_med_window_gen.sv
// Directed bench for med_window_gen: line_len=4 instance for frame, timing,
// backpressure, SOF and reset cases; line_len=3 instance for throughput.
module tb_med_window_gen;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pi, do4;
  logic       pval, sof, prdy, wrdy, dso, sow;
  logic [1:0] st;
  logic [7:0] pi3, do3;
  logic       pval3, sof3, prdy3, wrdy3, dso3, sow3;
  logic [1:0] st3;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp3_q[$];
  int k_mon = 0, k3_mon = 0, sow_cnt = 0, sow3_cnt = 0, sow_base;
  logic [31:0] e4, e3;
  logic [7:0] ff_tab [36] = '{
    8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10,
    8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11,
    8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14,
    8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
  logic [7:0] mid_tab [18] = '{
    8'h48, 8'h49, 8'h4A, 8'h4C, 8'h4D, 8'h4E, 8'h80, 8'h81, 8'h82,
    8'h49, 8'h4A, 8'h4B, 8'h4D, 8'h4E, 8'h4F, 8'h81, 8'h82, 8'h83};

  always #5 clk = ~clk;

  med_window_gen #(.width(8), .line_len(4)) u_dut (
    .CLK(clk), .RST(rst), .PI(pi), .PVAL(pval), .SOF(sof), .PRDY(prdy),
    .WRDY(wrdy), .DO(do4), .DSO(dso), .SOW(sow), .fsm_state(st));

  med_window_gen #(.width(8), .line_len(3)) u_dut3 (
    .CLK(clk), .RST(rst), .PI(pi3), .PVAL(pval3), .SOF(sof3), .PRDY(prdy3),
    .WRDY(wrdy3), .DO(do3), .DSO(dso3), .SOW(sow3), .fsm_state(st3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v, input logic s);
    int n;
    n = 0;
    @(negedge clk);
    while (!prdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_prdy", prdy, 1);
    pi = v; sof = s; pval = 1'b1;
    @(posedge clk);
    #1;
    pval = 1'b0; sof = 1'b0;
  endtask

  // Window ending at (r,c) of a line_len=4 frame whose pixel (0,0) is base.
  task automatic push_win(input int base, input int r, input int c);
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        exp_q.push_back(8'(base + (r - 2 + dr) * 4 + (c - 2 + dc)));
  endtask

  task automatic drain(input string tag, input int bursts);
    repeat (12) @(negedge clk);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
    chk({tag, "_bursts"}, sow_cnt, bursts);
  endtask

  // Scoreboard: every strobed sample is matched against the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      k_mon = 0;
      k3_mon = 0;
    end else begin
      if (dso) begin
        e4 = 'x;
        if (exp_q.size() > 0) e4 = 32'(exp_q.pop_front());
        chk("do", do4, e4);
        chk("sow_first", sow, 32'(k_mon == 0));
        if (sow) sow_cnt++;
        k_mon = (k_mon == 8) ? 0 : k_mon + 1;
      end else begin
        chk("sow_idle", sow, 0);
      end
      if (dso3) begin
        e3 = 'x;
        if (exp3_q.size() > 0) e3 = 32'(exp3_q.pop_front());
        chk("do3", do3, e3);
        chk("sow3_first", sow3, 32'(k3_mon == 0));
        if (sow3) sow3_cnt++;
        k3_mon = (k3_mon == 8) ? 0 : k3_mon + 1;
      end else begin
        chk("sow3_idle", sow3, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pi = '0; pval = 1'b0; sof = 1'b0; wrdy = 1'b1;
    pi3 = '0; pval3 = 1'b0; sof3 = 1'b0; wrdy3 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_do", do4, 0);
    chk("rst_dso", dso, 0);
    chk("rst_sow", sow, 0);
    chk("rst_prdy", prdy, 1);
    rst = 1'b0;
    #1;
    chk("rel_prdy", prdy, 1);
    chk("rel_state", st, ST_IDLE);
    chk("rel_prdy3", prdy3, 1);
    chk("rel_dso3", dso3, 0);

    // Full frame with timing check around pixel 10
    foreach (ff_tab[i]) exp_q.push_back(ff_tab[i]);
    for (int i = 0; i < 16; i++) begin
      send(8'(i), i == 0);
      if (i == 10) begin
        for (int c = 1; c <= 9; c++) begin
          @(negedge clk);
          chk("t_dso", dso, 1);
          chk("t_prdy", prdy, 0);
        end
        @(negedge clk);
        chk("t_prdy_back", prdy, 1);
        chk("t_dso_end", dso, 0);
      end
    end
    drain("full", 4);

    // Backpressure on the first window of a new frame
    push_win(8'h40, 2, 2); push_win(8'h40, 2, 3);
    push_win(8'h40, 3, 2); push_win(8'h40, 3, 3);
    for (int i = 0; i < 16; i++) begin
      if (i == 10) wrdy = 1'b0;
      send(8'(8'h40 + i), i == 0);
      if (i == 10) begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("bp_state", st, ST_PEND);
          chk("bp_dso", dso, 0);
          chk("bp_prdy", prdy, 0);
        end
        wrdy = 1'b1;
        @(negedge clk);
        chk("bp_start_dso", dso, 1);
        chk("bp_start_state", st, ST_EMIT);
      end
    end
    drain("bp", 8);

    // Continue past frame end, then SOF on the 7th pixel
    foreach (mid_tab[i]) exp_q.push_back(mid_tab[i]);
    for (int j = 0; j < 6; j++) send(8'(8'h80 + j), 1'b0);
    drain("pre_sof", 10);
    for (int p = 0; p < 10; p++) send(8'(8'h86 + p), p == 0);
    repeat (3) @(negedge clk);
    chk("sof_no_early", sow_cnt, 10);
    push_win(8'h86, 2, 2); push_win(8'h86, 2, 3);
    push_win(8'h86, 3, 2); push_win(8'h86, 3, 3);
    for (int p = 10; p < 16; p++) send(8'(8'h86 + p), 1'b0);
    drain("post_sof", 14);

    // Reset during k=4 of a burst
    push_win(8'hC0, 2, 2);
    for (int i = 0; i <= 10; i++) send(8'(8'hC0 + i), i == 0);
    repeat (5) @(negedge clk);
    chk("pre_rst_dso", dso, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_dso", dso, 0);
    chk("mid_rst_do", do4, 0);
    chk("mid_rst_sow", sow, 0);
    chk("mid_rst_prdy", prdy, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_prdy", prdy, 1);
    chk("post_rst_state", st, ST_IDLE);
    sow_base = sow_cnt;
    foreach (ff_tab[i]) exp_q.push_back(ff_tab[i]);
    for (int i = 0; i < 16; i++) send(8'(i), i == 0);
    drain("rerun", sow_base + 4);

    // Throughput: line_len=3, PVAL held high for a whole frame
    for (int i = 0; i < 9; i++) exp3_q.push_back(8'(i));
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("tp_prdy", prdy3, 1);
      pi3 = 8'(i); sof3 = (i == 0); pval3 = 1'b1;
    end
    @(negedge clk);
    pval3 = 1'b0; sof3 = 1'b0;
    repeat (12) @(negedge clk);
    chk("tp_q_empty", exp3_q.size(), 0);
    chk("tp_bursts", sow3_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
